// File: rtl/sd_pkg.sv
// Shared types and constants for the SD single-block read engine.
package sd_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TOK_ISSUE,
    S_TOK_WAIT,
    S_CRC_CLR,
    S_DATA_ISSUE,
    S_DATA_WAIT,
    S_CRC_ISSUE,
    S_CRC_WAIT,
    S_CMP,
    S_FINISH
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_CRC     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_TOKEN   = 2'b11;

  localparam logic [7:0] TOKEN_START = 8'hFE;
  localparam logic [7:0] IDLE_BYTE   = 8'hFF;

endpackage

// File: rtl/sd_stream_hold.sv
// One-entry valid/ready output register; a load in the same cycle as an
// accept replaces the data and keeps m_valid high.
module sd_stream_hold (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       room,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready
);

  assign room = !m_valid || m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (load) begin
      m_data  <= load_data;
      m_valid <= 1'b1;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sd_block_reader.sv
// Single-block SD read engine: polls for the start token, streams the data
// block through a one-entry hold register and checks the trailing CRC16.
module sd_block_reader
  import sd_pkg::*;
#(
  parameter int BLOCK_BYTES   = 512,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        abort,
  output logic        active,
  output logic        done,
  output logic [1:0]  status,
  output logic        sh_start_read,
  input  logic        sh_busy,
  input  logic [7:0]  sh_data,
  output logic        sh_crc_reset,
  output logic        sh_crc_source,
  input  logic [15:0] sh_crc,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready
);

  localparam int PW = $clog2(TOKEN_TIMEOUT + 1);
  localparam int BW = $clog2(BLOCK_BYTES + 1);
  localparam logic [PW-1:0] POLL_LIMIT = PW'(TOKEN_TIMEOUT);
  localparam logic [BW-1:0] BYTE_LIMIT = BW'(BLOCK_BYTES);

  state_t          state;
  logic [PW-1:0]   poll_cnt;
  logic [PW-1:0]   poll_nxt;
  logic [BW-1:0]   byte_cnt;
  logic [BW-1:0]   byte_nxt;
  logic [15:0]     crc_exp;
  logic [15:0]     crc_rx;
  logic            crc_hi_done;
  logic [1:0]      stat_r;
  logic            hold_room;
  logic            hold_load;
  logic            hold_flush;

  assign sh_crc_source = 1'b1;
  assign poll_nxt      = poll_cnt + PW'(1);
  assign byte_nxt      = byte_cnt + BW'(1);
  assign hold_load     = (state == S_DATA_WAIT) && !sh_busy && !abort;
  assign hold_flush    = (state != S_IDLE) && abort;

  // The data issue depends on this cycle's m_ready, so the read request is
  // decoded from state rather than registered a cycle early.
  always_comb begin
    sh_start_read = 1'b0;
    if (!abort && !sh_busy) begin
      case (state)
        S_TOK_ISSUE, S_CRC_ISSUE: sh_start_read = 1'b1;
        S_DATA_ISSUE:             sh_start_read = hold_room;
        default:                  sh_start_read = 1'b0;
      endcase
    end
  end

  sd_stream_hold u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (hold_flush),
    .load      (hold_load),
    .load_data (sh_data),
    .room      (hold_room),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      active       <= 1'b0;
      done         <= 1'b0;
      status       <= ST_OK;
      sh_crc_reset <= 1'b0;
      poll_cnt     <= '0;
      byte_cnt     <= '0;
      crc_exp      <= '0;
      crc_rx       <= '0;
      crc_hi_done  <= 1'b0;
      stat_r       <= ST_OK;
    end else begin
      done         <= 1'b0;
      sh_crc_reset <= 1'b0;
      if (state != S_IDLE && abort) begin
        state  <= S_IDLE;
        active <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (go && !sh_busy) begin
              state    <= S_TOK_ISSUE;
              active   <= 1'b1;
              poll_cnt <= '0;
            end
          end
          S_TOK_ISSUE: begin
            if (sh_start_read) state <= S_TOK_WAIT;
          end
          S_TOK_WAIT: begin
            if (!sh_busy) begin
              if (sh_data == TOKEN_START) begin
                state        <= S_CRC_CLR;
                sh_crc_reset <= 1'b1;
              end else if (sh_data == IDLE_BYTE) begin
                poll_cnt <= poll_nxt;
                if (poll_nxt == POLL_LIMIT) begin
                  stat_r <= ST_TIMEOUT;
                  state  <= S_FINISH;
                end else begin
                  state <= S_TOK_ISSUE;
                end
              end else begin
                stat_r <= ST_TOKEN;
                state  <= S_FINISH;
              end
            end
          end
          S_CRC_CLR: begin
            byte_cnt <= '0;
            state    <= S_DATA_ISSUE;
          end
          S_DATA_ISSUE: begin
            if (sh_start_read) state <= S_DATA_WAIT;
          end
          S_DATA_WAIT: begin
            if (!sh_busy) begin
              byte_cnt <= byte_nxt;
              if (byte_nxt == BYTE_LIMIT) begin
                crc_exp     <= sh_crc;
                crc_hi_done <= 1'b0;
                state       <= S_CRC_ISSUE;
              end else begin
                state <= S_DATA_ISSUE;
              end
            end
          end
          S_CRC_ISSUE: begin
            if (sh_start_read) state <= S_CRC_WAIT;
          end
          S_CRC_WAIT: begin
            if (!sh_busy) begin
              if (!crc_hi_done) begin
                crc_rx[15:8] <= sh_data;
                crc_hi_done  <= 1'b1;
                state        <= S_CRC_ISSUE;
              end else begin
                crc_rx[7:0] <= sh_data;
                state       <= S_CMP;
              end
            end
          end
          S_CMP: begin
            stat_r <= (crc_rx == crc_exp) ? ST_OK : ST_CRC;
            state  <= S_FINISH;
          end
          S_FINISH: begin
            if (!m_valid) begin
              done   <= 1'b1;
              status <= stat_r;
              active <= 1'b0;
              state  <= S_IDLE;
            end
          end
          default: begin
            state  <= S_IDLE;
            active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_block_reader.sv
// Self-checking bench for sd_block_reader with a behavioural SPI shifter/card model.
module tb_sd_block_reader;

  localparam int BB = 512;
  localparam int TT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic        active, done, sh_start_read, sh_crc_reset, sh_crc_source, m_valid;
  logic [1:0]  status;
  logic        sh_busy;
  logic [7:0]  sh_data, m_data;
  logic [15:0] sh_crc;
  logic        m_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] resp [0:1023];
  int         gen = 0;
  int         last_gen = 0;
  int         tok_pos = 0;
  int         rd_idx, remain;
  logic [7:0] pend;

  int         n_start, n_done, n_contract, n_stall;
  int         ready_pct = 100;
  logic [7:0] got [$];
  logic [1:0] last_exp_st = 2'b00;

  always #5 clk = ~clk;

  sd_block_reader #(.BLOCK_BYTES(BB), .TOKEN_TIMEOUT(TT)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .active(active), .done(done),
    .status(status), .sh_start_read(sh_start_read), .sh_busy(sh_busy), .sh_data(sh_data),
    .sh_crc_reset(sh_crc_reset), .sh_crc_source(sh_crc_source), .sh_crc(sh_crc),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[15] ^ d[7-i];
      r = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // Shifter + card: a started byte stays busy 1..3 cycles, CRC16 tracks MISO bytes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_busy <= 1'b0;
      sh_data <= 8'h00;
      sh_crc  <= 16'h0000;
      remain  <= 0;
      rd_idx  <= 0;
    end else begin
      if (sh_crc_reset) sh_crc <= 16'h0000;
      if (gen != last_gen) begin
        rd_idx   <= 0;
        last_gen <= gen;
      end else if (sh_busy) begin
        if (remain == 1) begin
          sh_busy <= 1'b0;
          sh_data <= pend;
          sh_crc  <= crc16_byte(sh_crc, pend);
        end
        remain <= remain - 1;
      end else if (sh_start_read) begin
        sh_busy <= 1'b1;
        remain  <= $urandom_range(1, 3);
        pend    <= (rd_idx < 1024) ? resp[rd_idx] : 8'hFF;
        rd_idx  <= rd_idx + 1;
      end
    end
  end

  // Consumer and protocol monitor: values seen at negedge+1 are those the next posedge acts on.
  always @(negedge clk) begin
    m_ready = ($urandom_range(0, 99) < ready_pct);
    #1;
    if (rst_n) begin
      if (m_valid && m_ready) got.push_back(m_data);
      if (sh_start_read) n_start++;
      if (done) n_done++;
      if (sh_start_read && (sh_busy || sh_crc_reset)) n_contract++;
      if (sh_start_read && m_valid && !m_ready && rd_idx > tok_pos && rd_idx <= tok_pos + BB)
        n_stall++;
    end
  end

  task automatic prep_resp(input int nff, input logic [7:0] tok, input logic [15:0] flip,
                           input bit ramp);
    int k;
    logic [7:0] d;
    logic [15:0] c;
    k = 0;
    c = 16'h0000;
    for (int i = 0; i < nff; i++) begin resp[k] = 8'hFF; k++; end
    resp[k] = tok; k++;
    tok_pos = nff;
    if (tok == 8'hFE) begin
      for (int i = 0; i < BB; i++) begin
        d = ramp ? 8'(i) : 8'($urandom);
        resp[k] = d; k++;
        c = crc16_byte(c, d);
      end
      c = c ^ flip;
      resp[k] = c[15:8]; k++;
      resp[k] = c[7:0];  k++;
    end
    for (int i = k; i < 1024; i++) resp[i] = 8'hFF;
  endtask

  task automatic launch(input int pct);
    int cyc;
    cyc = 0;
    while (sh_busy && cyc < 100) begin @(negedge clk); cyc++; end
    @(negedge clk);
    gen++;
    n_start = 0; n_done = 0; n_contract = 0; n_stall = 0;
    got.delete();
    ready_pct = pct;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic run_read(input string name, input int nff, input logic [7:0] tok,
                          input logic [15:0] flip, input int pct, input bit ramp);
    int k, polls, exp_starts, cyc, bad;
    logic [1:0] exp_st;
    logic [15:0] c;
    logic [7:0] exp_q [$];
    prep_resp(nff, tok, flip, ramp);
    // Reference: walk the card's byte stream with the read rules.
    k = 0; polls = 0; exp_st = 2'b00;
    forever begin
      if (resp[k] == 8'hFF) begin
        polls++; k++;
        if (polls == TT) begin exp_st = 2'b10; break; end
      end else if (resp[k] == 8'hFE) begin
        c = 16'h0000;
        for (int i = 1; i <= BB; i++) begin
          c = crc16_byte(c, resp[k+i]);
          exp_q.push_back(resp[k+i]);
        end
        exp_st = (c == {resp[k+BB+1], resp[k+BB+2]}) ? 2'b00 : 2'b01;
        k = k + 1 + BB + 2;
        break;
      end else begin
        k++; exp_st = 2'b11; break;
      end
    end
    exp_starts = k;
    last_exp_st = exp_st;
    launch(pct);
    cyc = 0;
    while (n_done == 0 && cyc < 30000) begin @(negedge clk); cyc++; end
    repeat (4) @(negedge clk);
    n_tests++;
    if (n_done !== 1) begin
      n_fail++; $display("FAIL %s done_pulses got=%0d want=1", name, n_done);
    end
    n_tests++;
    if (status !== exp_st) begin
      n_fail++; $display("FAIL %s status got=%b want=%b", name, status, exp_st);
    end
    n_tests++;
    if (n_start !== exp_starts) begin
      n_fail++; $display("FAIL %s start_reads got=%0d want=%0d", name, n_start, exp_starts);
    end
    n_tests++;
    if (got.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL %s stream_len got=%0d want=%0d", name, got.size(), exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) bad++;
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL %s stream_data wrong_bytes got=%0d want=0", name, bad);
    end
    n_tests++;
    if (n_stall !== 0) begin
      n_fail++; $display("FAIL %s issue_while_full got=%0d want=0", name, n_stall);
    end
    n_tests++;
    if (n_contract !== 0) begin
      n_fail++; $display("FAIL %s shifter_contract got=%0d want=0", name, n_contract);
    end
    n_tests++;
    if (active !== 1'b0) begin
      n_fail++; $display("FAIL %s active_after got=%b want=0", name, active);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if ({active, done, sh_start_read, sh_crc_reset, m_valid, status, m_data, sh_crc_source}
        !== {5'b00000, 2'b00, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b%b%b%b%b_%b_%h_%b want=00000_00_00_1",
               active, done, sh_start_read, sh_crc_reset, m_valid, status, m_data, sh_crc_source);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();   run_read("basic",   3, 8'hFE, 16'h0000, 100, 1'b1); endtask
  task automatic test_crc_err(); run_read("crc_err", 1, 8'hFE, 16'h0400, 100, 1'b1); endtask
  task automatic test_timeout(); run_read("timeout", 40, 8'hFF, 16'h0000, 100, 1'b0); endtask
  task automatic test_bad_token(); run_read("bad_token", 0, 8'h05, 16'h0000, 100, 1'b0); endtask
  task automatic test_backpressure();
    run_read("backpressure", $urandom_range(0, 5), 8'hFE, 16'h0000, 30, 1'b0);
  endtask

  task automatic test_abort();
    int cyc;
    prep_resp(2, 8'hFE, 16'h0000, 1'b0);
    launch(100);
    cyc = 0;
    while (got.size() < 100 && cyc < 5000) begin @(negedge clk); cyc++; end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (30) @(negedge clk);
    n_tests++;
    if (cyc >= 5000) begin
      n_fail++; $display("FAIL abort_reach_byte100 got=%0d want>=100", got.size());
    end
    n_tests++;
    if (n_done !== 0) begin
      n_fail++; $display("FAIL abort_no_done got=%0d want=0", n_done);
    end
    n_tests++;
    if ({active, m_valid} !== 2'b00) begin
      n_fail++; $display("FAIL abort_idle active/valid got=%b%b want=00", active, m_valid);
    end
    n_tests++;
    if (status !== last_exp_st) begin
      n_fail++; $display("FAIL abort_status_kept got=%b want=%b", status, last_exp_st);
    end
    run_read("after_abort", 1, 8'hFE, 16'h0000, 70, 1'b0);
  endtask

  task automatic test_reset_mid();
    int cyc;
    prep_resp(0, 8'hFE, 16'h0000, 1'b0);
    launch(100);
    cyc = 0;
    while (got.size() < 50 && cyc < 5000) begin @(negedge clk); cyc++; end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({active, done, sh_start_read, sh_crc_reset, m_valid, status, m_data}
        !== {5'b00000, 2'b00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_mid_outputs got=%b%b%b%b%b_%b_%h want=00000_00_00",
               active, done, sh_start_read, sh_crc_reset, m_valid, status, m_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_read("after_reset", 2, 8'h05, 16'h0000, 100, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_crc_err();
    test_timeout();
    test_bad_token();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
